// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register built as a 2-entry skid buffer (head + skid) with forwarding taps.
// Optional misaligned-access detection is enabled by defining EX_MEM_MISALIGN_CHECK_EN.
module ex_mem_reg #(
    parameter int XLEN = 64
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] ex_alu_res,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_pc_plus_4,
    input  logic [1:0]      ex_wb_select,
    input  logic            ex_mem_wen,
    input  logic [1:0]      ex_mem_size,
    input  logic [4:0]      ex_rd,
    input  logic            ex_rd_wen,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_alu_res,
    output logic [XLEN-1:0] out_rs2,
    output logic [XLEN-1:0] out_pc_plus_4,
    output logic [1:0]      out_wb_select,
    output logic [7:0]      out_write_width,
    output logic            out_write_enable,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            fwd_is_load,
    output logic            misalign
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] pc4;
        logic [1:0]      wb_sel;
        logic            mem_wen;
        logic [7:0]      wmask;
        logic [4:0]      rd;
        logic            rd_wen;
        logic            mis;
    } entry_t;

    state_t r_state;
    state_t w_state_next;
    entry_t r_head;
    entry_t r_skid;
    entry_t w_head_next;
    entry_t w_skid_next;
    entry_t w_in_entry;
    logic   r_in_ready;
    logic   w_accept;
    logic   w_deliver;
    logic   w_in_mis;
    logic [7:0] w_in_mask;

    always_comb begin
        w_in_mask = 8'h01;
        case (ex_mem_size)
            2'd0:    w_in_mask = 8'h01;
            2'd1:    w_in_mask = 8'h03;
            2'd2:    w_in_mask = 8'h0F;
            default: w_in_mask = 8'hFF;
        endcase
    end

`ifdef EX_MEM_MISALIGN_CHECK_EN
    // Only memory operations (loads and stores) can be misaligned; byte accesses never are.
    always_comb begin
        w_in_mis = 1'b0;
        if ((ex_wb_select == 2'b01) || ex_mem_wen) begin
            case (ex_mem_size)
                2'd1:    w_in_mis = ex_alu_res[0];
                2'd2:    w_in_mis = |ex_alu_res[1:0];
                2'd3:    w_in_mis = |ex_alu_res[2:0];
                default: w_in_mis = 1'b0;
            endcase
        end
    end
`else
    assign w_in_mis = 1'b0;
`endif

    always_comb begin
        w_in_entry         = '0;
        w_in_entry.alu     = ex_alu_res;
        w_in_entry.rs2     = ex_rs2;
        w_in_entry.pc4     = ex_pc_plus_4;
        w_in_entry.wb_sel  = ex_wb_select;
        w_in_entry.mem_wen = ex_mem_wen;
        w_in_entry.wmask   = w_in_mask;
        w_in_entry.rd      = ex_rd;
        w_in_entry.rd_wen  = ex_rd_wen;
        w_in_entry.mis     = w_in_mis;
    end

    assign w_accept  = in_valid && r_in_ready && !flush;
    assign w_deliver = out_valid && out_ready;

    always_comb begin
        w_state_next = r_state;
        w_head_next  = r_head;
        w_skid_next  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = ST_ONE;
                    w_head_next  = w_in_entry;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_deliver) begin
                    w_state_next = ST_TWO;
                    w_skid_next  = w_in_entry;
                end else if (w_deliver && !w_accept) begin
                    w_state_next = ST_EMPTY;
                end else if (w_deliver && w_accept) begin
                    w_head_next  = w_in_entry;
                end
            end
            ST_TWO: begin
                if (w_deliver) begin
                    w_state_next = ST_ONE;
                    w_head_next  = r_skid;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
        if (flush) begin
            w_state_next = ST_EMPTY;
        end
    end

    // in_ready is registered off the next state so it never depends on out_ready combinationally.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= ST_EMPTY;
            r_head     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_head     <= w_head_next;
            r_skid     <= w_skid_next;
            r_in_ready <= (w_state_next != ST_TWO);
        end
    end

    assign in_ready         = r_in_ready;
    assign out_valid        = (r_state == ST_ONE) || (r_state == ST_TWO);
    assign out_alu_res      = r_head.alu;
    assign out_rs2          = r_head.rs2;
    assign out_pc_plus_4    = r_head.pc4;
    assign out_wb_select    = r_head.wb_sel;
    assign out_write_width  = r_head.wmask;
    assign out_rd           = r_head.rd;
    assign misalign         = out_valid && r_head.mis;
    assign out_write_enable = out_valid && r_head.mem_wen && !misalign;
    assign out_rd_wen       = out_valid && r_head.rd_wen && (r_head.rd != 5'd0);
    assign fwd_valid        = out_rd_wen;
    assign fwd_rd           = r_head.rd;
    assign fwd_data         = (r_head.wb_sel == 2'b10) ? r_head.pc4 : r_head.alu;
    assign fwd_is_load      = fwd_valid && (r_head.wb_sel == 2'b01);

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed, table-driven bench for ex_mem_reg plus hand-written skid/flush/reset sequences.
module tb_ex_mem_reg;
    localparam int XLEN = 64;
`ifdef EX_MEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic            sys_clk = 1'b0;
    logic            sys_rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [XLEN-1:0] ex_alu_res, ex_rs2, ex_pc_plus_4;
    logic [1:0]      ex_wb_select, ex_mem_size;
    logic            ex_mem_wen, ex_rd_wen;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] out_alu_res, out_rs2, out_pc_plus_4, fwd_data;
    logic [1:0]      out_wb_select;
    logic [7:0]      out_write_width;
    logic            out_write_enable, out_rd_wen, fwd_valid, fwd_is_load, misalign;
    logic [4:0]      out_rd, fwd_rd;

    int n_cmp = 0;
    int n_bad = 0;

    ex_mem_reg #(.XLEN(XLEN)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ex_alu_res(ex_alu_res), .ex_rs2(ex_rs2), .ex_pc_plus_4(ex_pc_plus_4),
        .ex_wb_select(ex_wb_select), .ex_mem_wen(ex_mem_wen), .ex_mem_size(ex_mem_size),
        .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_res(out_alu_res), .out_rs2(out_rs2), .out_pc_plus_4(out_pc_plus_4),
        .out_wb_select(out_wb_select), .out_write_width(out_write_width),
        .out_write_enable(out_write_enable), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .fwd_is_load(fwd_is_load), .misalign(misalign)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic            iv;
        logic [XLEN-1:0] alu, rs2, pc4;
        logic [1:0]      wb;
        logic            wen;
        logic [1:0]      size;
        logic [4:0]      rd;
        logic            rdwen;
        logic            e_ov;
        logic [7:0]      e_ww;
        logic            e_we, e_rdwen, e_fv;
        logic [XLEN-1:0] e_fdata;
        logic            e_fload, e_mis;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rs2,
                         input logic [XLEN-1:0] pc4, input logic [1:0] wb, input logic wen,
                         input logic [1:0] size, input logic [4:0] rd, input logic rdwen);
        in_valid = iv; ex_alu_res = alu; ex_rs2 = rs2; ex_pc_plus_4 = pc4;
        ex_wb_select = wb; ex_mem_wen = wen; ex_mem_size = size; ex_rd = rd; ex_rd_wen = rdwen;
    endtask

    initial begin
        // in alu rs2 pc4 wb wen size rd rdwen | ov ww we rdwen fv fdata fload mis
        vecs[0] = '{1'b1, 64'h10, 64'hDEADBEEF, 64'h14, 2'b00, 1'b1, 2'd2, 5'd0, 1'b0,
                    1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 64'h10, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 64'h200, 64'h0, 64'h18, 2'b01, 1'b0, 2'd3, 5'd5, 1'b1,
                    1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 64'h200, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 64'h40, 64'h0, 64'h1C, 2'b01, 1'b0, 2'd2, 5'd0, 1'b1,
                    1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 64'h40, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 64'h999, 64'h0, 64'h104, 2'b10, 1'b0, 2'd0, 5'd1, 1'b1,
                    1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 64'h104, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 64'h21, 64'h1234, 64'h20, 2'b00, 1'b1, 2'd1, 5'd0, 1'b0,
                    1'b1, 8'h03, !MIS_EN, 1'b0, 1'b0, 64'h21, 1'b0, MIS_EN};
        vecs[5] = '{1'b1, 64'h23, 64'hAB, 64'h24, 2'b00, 1'b1, 2'd0, 5'd0, 1'b0,
                    1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 64'h23, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 64'hABCD, 64'h0, 64'h28, 2'b00, 1'b0, 2'd2, 5'd31, 1'b1,
                    1'b1, 8'h0F, 1'b0, 1'b1, 1'b1, 64'hABCD, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 64'h104, 64'h0, 64'h2C, 2'b01, 1'b0, 2'd3, 5'd3, 1'b1,
                    1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 64'h104, 1'b1, MIS_EN};
        vecs[8] = '{1'b0, 64'h0, 64'h0, 64'h0, 2'b00, 1'b0, 2'd0, 5'd0, 1'b0,
                    1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0};

        sys_rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, '0, '0, '0, 2'b00, 1'b0, 2'd0, 5'd0, 1'b0);
        step();
        step();
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_we", 64'(out_write_enable), 64'h0);
        chk("rst_rd_wen", 64'(out_rd_wen), 64'h0);
        chk("rst_fwd_valid", 64'(fwd_valid), 64'h0);
        chk("rst_misalign", 64'(misalign), 64'h0);
        chk("rst_alu", out_alu_res, 64'h0);
        $display("txn reset: in_ready=%0b out_valid=%0b", in_ready, out_valid);
        sys_rst = 1'b0;

        // Streaming table: each vector is one cycle with out_ready=1, so the head is always the latest entry.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].iv, vecs[i].alu, vecs[i].rs2, vecs[i].pc4, vecs[i].wb,
                  vecs[i].wen, vecs[i].size, vecs[i].rd, vecs[i].rdwen);
            step();
            $display("txn vec%0d: out_valid=%0b alu=%h ww=%h we=%0b fwd_valid=%0b fwd_data=%h mis=%0b",
                     i, out_valid, out_alu_res, out_write_width, out_write_enable, fwd_valid, fwd_data, misalign);
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'h1);
            chk($sformatf("v%0d_we", i), 64'(out_write_enable), 64'(vecs[i].e_we));
            chk($sformatf("v%0d_rd_wen", i), 64'(out_rd_wen), 64'(vecs[i].e_rdwen));
            chk($sformatf("v%0d_fwd_valid", i), 64'(fwd_valid), 64'(vecs[i].e_fv));
            chk($sformatf("v%0d_misalign", i), 64'(misalign), 64'(vecs[i].e_mis));
            chk($sformatf("v%0d_fwd_is_load", i), 64'(fwd_is_load), 64'(vecs[i].e_fload));
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d_write_width", i), 64'(out_write_width), 64'(vecs[i].e_ww));
                chk($sformatf("v%0d_fwd_data", i), fwd_data, vecs[i].e_fdata);
                chk($sformatf("v%0d_alu", i), out_alu_res, vecs[i].alu);
                chk($sformatf("v%0d_rs2", i), out_rs2, vecs[i].rs2);
                chk($sformatf("v%0d_pc4", i), out_pc_plus_4, vecs[i].pc4);
                chk($sformatf("v%0d_wb_sel", i), 64'(out_wb_select), 64'(vecs[i].wb));
                chk($sformatf("v%0d_fwd_rd", i), 64'(fwd_rd), 64'(vecs[i].rd));
                chk($sformatf("v%0d_out_rd", i), 64'(out_rd), 64'(vecs[i].rd));
            end
        end

        // Backpressure: A, B fill both slots, C waits; then drain in order A, B, C.
        out_ready = 1'b0;
        drive(1'b1, 64'hA00, 64'h1, 64'h0, 2'b00, 1'b0, 2'd2, 5'd7, 1'b1);
        step();
        chk("bp_A_in_ready", 64'(in_ready), 64'h1);
        chk("bp_A_head", out_alu_res, 64'hA00);
        drive(1'b1, 64'hB00, 64'h2, 64'h0, 2'b00, 1'b0, 2'd2, 5'd8, 1'b1);
        step();
        chk("bp_B_in_ready", 64'(in_ready), 64'h0);
        chk("bp_B_head_held", out_alu_res, 64'hA00);
        drive(1'b1, 64'hC00, 64'h3, 64'h0, 2'b00, 1'b0, 2'd2, 5'd9, 1'b1);
        step();
        step();
        chk("bp_C_in_ready", 64'(in_ready), 64'h0);
        chk("bp_C_head_held", out_alu_res, 64'hA00);
        chk("bp_C_out_rd", 64'(out_rd), 64'd7);
        $display("txn backpressure full: in_ready=%0b head=%h", in_ready, out_alu_res);
        out_ready = 1'b1;
        step();
        chk("bp_exit_B", out_alu_res, 64'hB00);
        chk("bp_exit_B_in_ready", 64'(in_ready), 64'h1);
        step();
        chk("bp_exit_C", out_alu_res, 64'hC00);
        chk("bp_exit_C_valid", 64'(out_valid), 64'h1);
        in_valid = 1'b0;
        step();
        chk("bp_drained", 64'(out_valid), 64'h0);
        $display("txn backpressure drain: out_valid=%0b", out_valid);

        // Flush while full with a simultaneous in_valid: nothing survives, nothing accepted.
        out_ready = 1'b0;
        drive(1'b1, 64'hD00, 64'h0, 64'h0, 2'b00, 1'b1, 2'd2, 5'd0, 1'b0);
        step();
        drive(1'b1, 64'hE00, 64'h0, 64'h0, 2'b00, 1'b1, 2'd2, 5'd0, 1'b0);
        step();
        chk("fl_full_in_ready", 64'(in_ready), 64'h0);
        flush = 1'b1;
        drive(1'b1, 64'hF00, 64'h0, 64'h0, 2'b00, 1'b1, 2'd2, 5'd0, 1'b0);
        step();
        chk("fl_out_valid", 64'(out_valid), 64'h0);
        chk("fl_in_ready", 64'(in_ready), 64'h1);
        chk("fl_we", 64'(out_write_enable), 64'h0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("fl_no_delivery", 64'(out_valid), 64'h0);
        $display("txn flush: out_valid=%0b in_ready=%0b", out_valid, in_ready);

        // Reset mid-operation wins over flush and handshake and clears datapath.
        out_ready = 1'b0;
        drive(1'b1, 64'h1100, 64'h55, 64'h0, 2'b00, 1'b1, 2'd2, 5'd4, 1'b1);
        step();
        step();
        sys_rst = 1'b1; flush = 1'b1;
        step();
        chk("mr_out_valid", 64'(out_valid), 64'h0);
        chk("mr_in_ready", 64'(in_ready), 64'h1);
        chk("mr_alu", out_alu_res, 64'h0);
        chk("mr_rs2", out_rs2, 64'h0);
        chk("mr_fwd_valid", 64'(fwd_valid), 64'h0);
        sys_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("mr_stays_empty", 64'(out_valid), 64'h0);
        $display("txn midreset: out_valid=%0b in_ready=%0b", out_valid, in_ready);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
